// File: rtl/pbch_dmrs_gen_if.sv
// AXI-stream bundle carrying PBCH DMRS QPSK bit pairs, each tagged with its ibar_SSB.
interface pbch_dmrs_gen_if;
  logic [1:0] tdata;
  logic [2:0] tuser;
  logic       tlast;
  logic       tvalid;
  logic       tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/pbch_dmrs_gen.sv
// PBCH DMRS Gold-sequence generator: derives c_init, skips NC samples, then streams
// {c(2m+1), c(2m)} pairs for one ibar_SSB or for every candidate 0..L_MAX-1.
module pbch_dmrs_gen #(
  parameter int SEQ_LEN     = 144,
  parameter int NC          = 1600,
  parameter int L_MAX       = 8,
  parameter int MAX_CELL_ID = 1007
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [$clog2(MAX_CELL_ID)-1:0] N_id_i,
  input  logic                           N_id_valid_i,
  input  logic [2:0]                     ibar_i,
  input  logic                           sweep_i,
  pbch_dmrs_gen_if.master                m_axis_out,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int NID_W       = $clog2(MAX_CELL_ID);
  localparam int SKIP_CYCLES = NC / 2;
  localparam int SKIP_W      = (SKIP_CYCLES > 1) ? $clog2(SKIP_CYCLES) : 1;
  localparam int BEAT_W      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SKIP, S_STREAM, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [30:0]       x1_q, x1_d;
  logic [30:0]       x2_q, x2_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [NID_W-1:0]  nid_q, nid_d;
  logic [2:0]        ibar_q, ibar_d;
  logic              sweep_q, sweep_d;

  logic        start;
  logic        handshake;
  logic        last_beat;
  logic        more_seq;
  logic        skip_end;
  logic [3:0]  ibar_p1;
  logic [30:0] c_init;

  // Bit k of each register holds x(n+k); one call moves n forward by two.
  function automatic logic [30:0] x1_step2(input logic [30:0] x);
    return {x[4] ^ x[1], x[3] ^ x[0], x[30:2]};
  endfunction

  function automatic logic [30:0] x2_step2(input logic [30:0] x);
    return {x[4] ^ x[3] ^ x[2] ^ x[1], x[3] ^ x[2] ^ x[1] ^ x[0], x[30:2]};
  endfunction

  assign start     = N_id_valid_i && (32'(N_id_i) <= 32'(MAX_CELL_ID));
  assign handshake = (state_q == S_STREAM) && m_axis_out.tready;
  assign last_beat = (beat_q == BEAT_W'(SEQ_LEN - 1));
  assign more_seq  = sweep_q && (32'(ibar_q) < 32'(L_MAX - 1));
  assign skip_end  = (skip_q == SKIP_W'(SKIP_CYCLES - 1));

  assign ibar_p1 = {1'b0, ibar_q} + 4'd1;
  assign c_init  = ((31'(ibar_p1) * (31'(nid_q[NID_W-1:2]) + 31'd1)) << 11)
                 + (31'(ibar_p1) << 6)
                 + 31'(nid_q[1:0]);

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = (SKIP_CYCLES == 0) ? S_STREAM : S_SKIP;
      S_SKIP:   if (skip_end) state_d = S_STREAM;
      S_STREAM: if (handshake && last_beat) state_d = more_seq ? S_LOAD : S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The LFSR pair itself is the output register: it only moves on an accepted beat,
  // so a stalled beat holds its data and the first pair is visible straight after SKIP.
  always_comb begin
    busy_o            = (state_q != S_IDLE);
    done_o            = (state_q == S_DONE);
    m_axis_out.tvalid = (state_q == S_STREAM);
    m_axis_out.tlast  = (state_q == S_STREAM) && last_beat;
    m_axis_out.tdata  = (state_q == S_STREAM) ? (x1_q[1:0] ^ x2_q[1:0]) : 2'b00;
    m_axis_out.tuser  = ibar_q;
  end

  always_comb begin
    x1_d    = x1_q;
    x2_d    = x2_q;
    skip_d  = skip_q;
    beat_d  = beat_q;
    nid_d   = nid_q;
    ibar_d  = ibar_q;
    sweep_d = sweep_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nid_d   = N_id_i;
          sweep_d = sweep_i;
          ibar_d  = sweep_i ? 3'd0 : ibar_i;
        end
      end
      S_LOAD: begin
        x1_d   = 31'd1;
        x2_d   = c_init;
        skip_d = '0;
        beat_d = '0;
      end
      S_SKIP: begin
        x1_d   = x1_step2(x1_q);
        x2_d   = x2_step2(x2_q);
        skip_d = skip_q + SKIP_W'(1);
      end
      S_STREAM: begin
        if (handshake) begin
          x1_d = x1_step2(x1_q);
          x2_d = x2_step2(x2_q);
          if (!last_beat) begin
            beat_d = beat_q + BEAT_W'(1);
          end else if (more_seq) begin
            ibar_d = ibar_q + 3'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x1_q    <= '0;
      x2_q    <= '0;
      skip_q  <= '0;
      beat_q  <= '0;
      nid_q   <= '0;
      ibar_q  <= '0;
      sweep_q <= 1'b0;
    end else begin
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      skip_q  <= skip_d;
      beat_q  <= beat_d;
      nid_q   <= nid_d;
      ibar_q  <= ibar_d;
      sweep_q <= sweep_d;
    end
  end

endmodule

// File: tb/tb_pbch_dmrs_gen.sv
// Scoreboard bench for pbch_dmrs_gen: a bit-array Gold-sequence model fills an expected
// queue, and a negedge monitor pops and compares every accepted beat.
module tb_pbch_dmrs_gen;

  localparam int SEQ_LEN     = 144;
  localparam int NC          = 1600;
  localparam int L_MAX       = 8;
  localparam int MAX_CELL_ID = 1007;
  localparam int NID_W       = $clog2(MAX_CELL_ID);
  localparam int LATENCY     = NC / 2 + 2;
  localparam int GAP         = NC / 2 + 1;

  typedef struct packed {
    logic [1:0] data;
    logic [2:0] user;
    logic       last;
  } beat_t;

  logic             clk_i        = 1'b0;
  logic             reset_i      = 1'b1;
  logic [NID_W-1:0] N_id_i       = '0;
  logic             N_id_valid_i = 1'b0;
  logic [2:0]       ibar_i       = 3'd0;
  logic             sweep_i      = 1'b0;
  logic             busy_o;
  logic             done_o;

  pbch_dmrs_gen_if axis ();

  pbch_dmrs_gen #(
    .SEQ_LEN    (SEQ_LEN),
    .NC         (NC),
    .L_MAX      (L_MAX),
    .MAX_CELL_ID(MAX_CELL_ID)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .N_id_i      (N_id_i),
    .N_id_valid_i(N_id_valid_i),
    .ibar_i      (ibar_i),
    .sweep_i     (sweep_i),
    .m_axis_out  (axis),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  beat_t exp_q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    done_cnt = 0;
  int    acc_cnt  = 0;
  bit    rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: the Gold sequence built sample by sample from the two recurrences.
  task automatic push_seq(input int nid, input int ibar);
    int    total;
    int    cinit;
    bit    x1[];
    bit    x2[];
    beat_t b;
    total = NC + 2 * SEQ_LEN;
    x1 = new[total + 31];
    x2 = new[total + 31];
    cinit = (ibar + 1) * (nid / 4 + 1) * 2048 + (ibar + 1) * 64 + nid % 4;
    for (int i = 0; i < 31; i++) begin
      x1[i] = (i == 0);
      x2[i] = bit'((cinit >> i) & 1);
    end
    for (int n = 0; n < total; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int m = 0; m < SEQ_LEN; m++) begin
      b.data = {x1[2*m+1+NC] ^ x2[2*m+1+NC], x1[2*m+NC] ^ x2[2*m+NC]};
      b.user = 3'(ibar);
      b.last = (m == SEQ_LEN - 1);
      exp_q.push_back(b);
    end
  endtask

  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  bit    gap_on     = 1'b0;
  int    low_run    = 0;

  always @(negedge clk_i) begin
    beat_t cur;
    beat_t e;
    cur = {axis.tdata, axis.tuser, axis.tlast};
    if (reset_i) begin
      prev_stall = 1'b0;
      gap_on     = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", 32'(cur), 32'(prev_beat));
      if (axis.tvalid && gap_on) begin
        check("sweep_gap", 32'(low_run), 32'(GAP));
        gap_on = 1'b0;
      end else if (!axis.tvalid && gap_on) begin
        low_run++;
      end
      if (axis.tvalid && axis.tready) begin
        acc_cnt++;
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", 32'(cur), 32'(e));
        end
        if (cur.last) begin
          gap_on  = 1'b1;
          low_run = 0;
        end
      end
      if (done_o) begin
        done_cnt++;
        gap_on = 1'b0;
      end
      prev_stall = axis.tvalid && !axis.tready;
      prev_beat  = cur;
    end
  end

  // intrude >= 0 strobes that N_id mid-stream and again in the done_o cycle.
  task automatic run_job(input int nid, input int ibar, input bit sweep, input int intrude);
    int n;
    int d0;
    bit seen;
    if (sweep) begin
      for (int i = 0; i < L_MAX; i++) push_seq(nid, i);
    end else begin
      push_seq(nid, ibar);
    end
    d0 = done_cnt;
    N_id_i       = NID_W'(nid);
    ibar_i       = 3'(ibar);
    sweep_i      = sweep;
    N_id_valid_i = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 4 * LATENCY) begin
      @(posedge clk_i);
      #1;
      n++;
      if (n == 1) N_id_valid_i = 1'b0;
      seen = axis.tvalid;
    end
    check("first_valid_latency", 32'(n), 32'(LATENCY));
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(posedge clk_i);
      #1;
      n++;
      N_id_valid_i = 1'b0;
      if (intrude >= 0 && (n == 20 || done_o)) begin
        N_id_i       = NID_W'(intrude);
        N_id_valid_i = 1'b1;
      end
    end
    N_id_valid_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    check("done_pulses", 32'(done_cnt - d0), 32'd1);
    check("beats_left", 32'(exp_q.size()), 32'd0);
    check("idle_after_job", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int n;
    int a0;
    int d0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs",
          32'({axis.tvalid, axis.tlast, axis.tdata, axis.tuser, busy_o, done_o}), 32'd0);
    reset_i = 1'b0;

    run_job(0, 0, 1'b0, -1);
    run_job(1007, 7, 1'b0, -1);
    run_job(500, 0, 1'b1, -1);
    run_job(123, 3, 1'b0, -1);
    rand_ready = 1'b1;
    run_job(123, 3, 1'b0, -1);
    rand_ready = 1'b0;
    run_job(9, 2, 1'b0, 5);

    // Out-of-range N_id must not start a job.
    N_id_i       = NID_W'(1010);
    ibar_i       = 3'd1;
    N_id_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    N_id_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("invalid_id_busy", 32'(busy_o), 32'd0);
      @(posedge clk_i);
      #1;
    end

    // Abort at beat 70, then rerun the same job from scratch.
    push_seq(321, 6);
    N_id_i       = NID_W'(321);
    ibar_i       = 3'd6;
    sweep_i      = 1'b0;
    N_id_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    N_id_valid_i = 1'b0;
    a0 = acc_cnt;
    n  = 0;
    while (acc_cnt - a0 < 70 && n < 5000) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("reached_beat_70", 32'(acc_cnt - a0), 32'd70);
    d0 = done_cnt;
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("tvalid_after_reset", 32'(axis.tvalid), 32'd0);
    check("busy_after_reset", 32'(busy_o), 32'd0);
    exp_q.delete();
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    reset_i = 1'b0;
    check("no_done_on_abort", 32'(done_cnt - d0), 32'd0);
    run_job(321, 6, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pbch_dmrs_gen.md
Name: pbch_dmrs_gen

Overview:
Parametrised Gold-sequence generator for the PBCH DMRS, per 38.211 §7.4.1.4.1. It derives c_init from N_id and ibar_SSB and performs the Nc warm-up skip internally. It streams QPSK bit pairs over an AXI-stream master with backpressure. An optional sweep mode generates the sequences for all ibar_SSB candidates back to back, for blind SSB-index detection downstream of the channel estimator.

Parameters:
SEQ_LEN, 144, output beats (bit pairs) per sequence; ≥1
NC, 1600, Gold sequence offset Nc; must be even
L_MAX, 8, number of ibar_SSB candidates in sweep mode (4 or 8)
MAX_CELL_ID, 1007, highest valid N_id; N_id width = $clog2(MAX_CELL_ID)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous, active-high reset
N_id_i  in  $clog2(MAX_CELL_ID)  physical cell ID
N_id_valid_i  in  1  start strobe; sampled only in IDLE
ibar_i  in  3  ibar_SSB for single mode
sweep_i  in  1  1 = sweep ibar 0..L_MAX-1; sampled with N_id_valid_i
m_axis_out_tdata  out  2  {c(2m+1), c(2m)}
m_axis_out_tuser  out  3  ibar_SSB of the current beat
m_axis_out_tlast  out  1  last beat (m = SEQ_LEN-1) of each sequence
m_axis_out_tvalid  out  1  beat valid
m_axis_out_tready  in  1  downstream ready
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse after the final beat of the job is accepted

Behaviour:
- Reset values: tdata=0, tuser=0, tlast=0, tvalid=0, busy_o=0, done_o=0. Reset places the FSM in IDLE and clears both LFSRs.
- Reset mid-job aborts immediately. tvalid is 0 in the cycle after reset is sampled, and no done_o pulse is produced.
- LFSRs are internal, 31 bits each, and advance 2 steps per clock.
  - x1: x1(n+31) = x1(n+3) ^ x1(n). Initial value x1(0)=1, all other bits 0.
  - x2: x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n). Initial value = c_init.
  - c(n) = x1(n+NC) ^ x2(n+NC).
- c_init = ((ibar+1)*(floor(N_id/4)+1) << 11) + ((ibar+1) << 6) + (N_id mod 4).
  - Computed in 31-bit unsigned arithmetic; the maximum value 4129283 fits without overflow.
- FSM:
  - IDLE: on N_id_valid_i, latch N_id_i, sweep_i, and ibar (ibar_i, or 0 when sweeping). Go to LOAD.
  - N_id_i > MAX_CELL_ID: the strobe is ignored and the FSM stays in IDLE.
  - LOAD (1 cycle): compute c_init; load x1 and x2. Go to SKIP.
  - SKIP: NC/2 cycles of 2-step advance; no output. Go to STREAM.
  - STREAM: the output register loads the next pair, and the LFSRs advance, only when tvalid=0 or (tvalid & tready).
  - While tvalid & !tready: tdata, tuser and tlast are held stable and the LFSRs are frozen.
  - Beat counter 0..SEQ_LEN-1; tlast=1 on beat SEQ_LEN-1.
  - When the tlast beat is accepted in sweep mode with ibar < L_MAX-1: ibar += 1 and go to LOAD.
  - When the tlast beat is accepted otherwise: tvalid drops the next cycle, done_o pulses, and the FSM returns to IDLE.
- Latency:
  - First tvalid rises NC/2 + 2 cycles after the cycle in which N_id_valid_i was accepted (802 at defaults).
  - Between sweep sequences, the gap is NC/2 + 1 cycles with tvalid=0.
- Throughput: 1 beat/cycle under continuous tready.
- N_id_valid_i while busy_o=1 is ignored; the running job is unaffected. A strobe in the same cycle as done_o is also ignored, because the FSM is not yet in IDLE.
- ibar_i ≥ L_MAX in single mode is used as given (3 bits); no clamping.
- The inter-beat gap and the tready pattern never change sequence content.

Test Plan:
- N_id=0, ibar=0, single mode, tready=1 → c_init=2112. Exactly 144 beats match the py3gpp golden model, tlast on beat 143, tuser=0, done_o pulses once, first tvalid 802 cycles after the strobe.
- N_id=1007, ibar=7 → c_init=4129283. All 144 beats match the golden model.
- N_id=500, sweep_i=1, L_MAX=8 → 8×144 beats, tuser stepping 0..7, tlast count = 8, 801-cycle tvalid-low gaps between sequences, a single done_o.
- Random tready (50% duty) with N_id=123, ibar=3 → the sequence is identical to the tready=1 run, and tdata is stable whenever tvalid & !tready.
- Strobe N_id=5 during STREAM of a job with N_id=9 → the output continues the N_id=9 sequence unchanged. A strobe with N_id=1010 in IDLE → busy_o stays 0.
- reset_i asserted at beat 70 → tvalid=0 next cycle, no done_o. A new job afterwards reproduces the full correct sequence from beat 0.
